// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: serialiser states,
// frame data width and the line idle level.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int   DATA_BITS  = 8;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with registered full/empty flags; a write while full
// is accepted when a read happens in the same cycle.
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_rd,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_full;
    logic             r_empty;

    logic             w_do_wr;
    logic             w_do_rd;
    logic [AW:0]      w_count_next;

    assign w_do_rd = i_rd && !r_empty;
    assign w_do_wr = i_wr && (!r_full || w_do_rd);

    always_comb begin
        w_count_next = r_count;
        if (w_do_wr && !w_do_rd) begin
            w_count_next = r_count + (AW+1)'(1);
        end else if (w_do_rd && !w_do_wr) begin
            w_count_next = r_count - (AW+1)'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Flags are registered from the next count so they track the count after each edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == FULL_COUNT);
            r_empty <= (w_count_next == '0);
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: FIFO plus serialiser FSM, LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115_200,
    parameter int DEPTH  = 16
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    // i_data_in_valid is a one-cycle strobe with no ready: the byte is either
    // queued on that edge or dropped and recorded in o_overflow.
    input  logic       i_data_in_valid,
    input  logic [7:0] i_data_in,
    input  logic       i_ovf_clr,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_empty,
    output logic       o_full,
    output logic       o_overflow
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int BW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W        = $clog2(DATA_BITS);
    localparam logic [BW-1:0]    BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);

    tx_state_t        r_state;
    logic             r_tx;
    logic             r_busy;
    logic             r_overflow;
    logic [7:0]       r_shift;
    logic [BIT_W-1:0] r_bit;
    logic [BW-1:0]    r_baud;
`ifdef UART_TX_PARITY_EN
    logic             r_parity;
`endif

    logic       w_empty;
    logic       w_full;
    logic [7:0] w_head;
    logic       w_baud_end;
    logic       w_pop;
    logic       w_drop;

    uart_tx_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_wr    (i_data_in_valid),
        .i_wdata (i_data_in),
        .i_rd    (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_baud_end = (r_baud == BAUD_LAST);
    // Loading from STOP as well as IDLE keeps back-to-back frames contiguous.
    assign w_pop  = !w_empty && ((r_state == IDLE) || ((r_state == STOP) && w_baud_end));
    assign w_drop = i_data_in_valid && w_full && !w_pop;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_tx     <= IDLE_LEVEL;
            r_busy   <= 1'b0;
            r_shift  <= '0;
            r_bit    <= '0;
            r_baud   <= '0;
`ifdef UART_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_tx <= IDLE_LEVEL;
                    if (w_pop) begin
                        r_shift  <= w_head;
                        r_bit    <= '0;
                        r_baud   <= '0;
                        r_state  <= START;
                        r_tx     <= 1'b0;
                        r_busy   <= 1'b1;
`ifdef UART_TX_PARITY_EN
                        r_parity <= ^w_head;
`endif
                    end
                end
                START: begin
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_state <= DATA;
                        r_tx    <= r_shift[0];
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                DATA: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (r_bit == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                            r_state <= PARITY;
                            r_tx    <= r_parity;
`else
                            r_state <= STOP;
                            r_tx    <= IDLE_LEVEL;
`endif
                        end else begin
                            r_shift <= r_shift >> 1;
                            r_tx    <= r_shift[1];
                            r_bit   <= r_bit + BIT_W'(1);
                        end
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                PARITY: begin
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_state <= STOP;
                        r_tx    <= IDLE_LEVEL;
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                STOP: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (w_pop) begin
                            r_shift  <= w_head;
                            r_bit    <= '0;
                            r_state  <= START;
                            r_tx     <= 1'b0;
`ifdef UART_TX_PARITY_EN
                            r_parity <= ^w_head;
`endif
                        end else begin
                            r_state <= IDLE;
                            r_tx    <= IDLE_LEVEL;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= IDLE_LEVEL;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // A drop in the same cycle as a clear wins so no lost byte goes unreported.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (i_ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

    assign o_tx       = r_tx;
    assign o_busy     = r_busy;
    assign o_empty    = w_empty;
    assign o_full     = w_full;
    assign o_overflow = r_overflow;

endmodule
